key_seq_checker: RTL
====================

KEY_SEQ_CHECKER -- requirements
Module: key_seq_checker

Interface
REQ-001 Parameter: W, default 4, width in bits of key values, count and key total.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  single-cycle pulse that begins a checking run.
REQ-005 Port: n_keys  input  W  number of keys expected in the run; sampled when start is accepted.
REQ-006 Port: deq_valid  input  1  priority queue has presented one dequeued key (kvo) this cycle.
REQ-007 Port: kvo  input  W  key value dequeued by the priority queue.
REQ-008 Port: verdict  input  1  error flag from the downstream comparator (1 = kvo/count mismatch).
REQ-009 Port: count  output  W  expected key value, driven to the comparator; 0 means no check is active.
REQ-010 Port: busy / done / pass  output  1 each  run in progress / run finished / finished with zero errors.
REQ-011 Port: first_err_key  output  W  kvo captured at the first mismatch of the run.
REQ-012 Port: err_cnt  output  W  mismatch count, present only under ERR_CNT_EN.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN, DONE, FAIL.
REQ-014 In IDLE, start with n_keys != 0 SHALL go to RUN, latch n_keys, set count=1, and clear the error state.
REQ-015 In IDLE, start with n_keys == 0 SHALL go directly to DONE with pass=1.
REQ-016 In RUN, each deq_valid cycle SHALL sample the same-cycle verdict (the comparator is combinational) as the result for the current count.
REQ-017 verdict=1 on an accepted dequeue SHALL set a sticky error flag, and on the run's first error SHALL capture kvo into first_err_key.
REQ-018 On an accepted dequeue with count < latched n_keys, count SHALL increment by 1 on the next edge.
REQ-019 On an accepted dequeue with count == latched n_keys, the next state SHALL be DONE when no error occurred in the run (including this dequeue), else FAIL; count SHALL return to 0.
REQ-020 Outcome latency: done, pass and the final state SHALL be valid on the cycle after the last dequeue.
REQ-021 count SHALL never wrap, because n_keys <= 2^W-1 bounds it.
REQ-022 deq_valid outside RUN SHALL be ignored: no state change and no error recorded.
REQ-023 verdict SHALL be ignored when deq_valid=0.
REQ-024 start while in RUN SHALL be ignored.
REQ-025 start in DONE or FAIL SHALL restart exactly as from IDLE, with outputs cleared on the same edge.
REQ-026 Output decode: busy=1 only in RUN; done=1 in DONE or FAIL; pass=1 only in DONE; count=0 outside RUN.
REQ-027 DONE and FAIL SHALL hold all outputs until start or rst.

Reset
REQ-028 rst SHALL force IDLE, count=0, busy=0, done=0, pass=0, first_err_key=0, err_cnt=0, and clear the sticky error flag.
REQ-029 rst SHALL take priority over every other input, including mid-run, where it aborts the run with no outcome reported.

Configuration
REQ-030 Macro ERR_CNT_EN: when defined, port err_cnt and its counter SHALL exist.
REQ-031 With ERR_CNT_EN, err_cnt SHALL increment per mismatching dequeue and saturate at 2^W-1.
REQ-032 With ERR_CNT_EN, err_cnt SHALL clear on an accepted start.
REQ-033 Without ERR_CNT_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-034 A shared package SHALL hold the state enum typedef (IDLE, RUN, DONE, FAIL) and the default key width constant (4).
REQ-035 The saturating error counter SHALL be a sub-module named sat_counter, instantiated only under ERR_CNT_EN.
REQ-036 The comparator SHALL stay external; the bench and top level SHALL wire count to it and verdict back from it.

Verification
REQ-037 Clean run: n_keys=5, kvo 1,2,3,4,5 on consecutive deq_valid -> count steps 1..5, then DONE with pass=1 and err_cnt=0 one cycle after the 5th dequeue.
REQ-038 Mismatch: n_keys=4, kvo 1,3,3,4 -> FAIL, first_err_key=3, err_cnt=1, pass=0.
REQ-039 Gaps and strays: deq_valid in IDLE with kvo=7 -> no change; in RUN, idle cycles between dequeues -> count holds and the run still completes correctly.
REQ-040 Boundary: start with n_keys=0 -> DONE and pass=1 next cycle; start with n_keys=15 and 15 correct dequeues -> count reaches 15 with no wrap, then DONE.
REQ-041 Reset and restart: rst asserted after 2 of 5 dequeues -> all outputs at reset values next cycle; start in FAIL -> RUN with count=1 and errors cleared.
REQ-042 Saturation (ERR_CNT_EN): 15 mismatching keys -> err_cnt=15 and FAIL; rebuilt without the macro -> same FSM outputs, with no err_cnt port.

Source files
------------

// File: rtl/key_seq_checker_pkg.sv
// Shared types and constants for the key sequence checker.
package key_seq_checker_pkg;

    localparam int KEY_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_t;

endpackage

// File: rtl/key_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/key_seq_checker.sv
// Checks that a priority queue dequeues keys 1..n_keys in order, using an external comparator.
// Optional error counter output err_cnt is built when ERR_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, outputs at reset values
// RUN   | expecting key 'count', one result per accepted dequeue
// DONE  | run finished with no mismatches, outputs held
// FAIL  | run finished with at least one mismatch, outputs held
module key_seq_checker
    import key_seq_checker_pkg::*;
#(
    parameter int W = KEY_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] n_keys,
    input  logic         deq_valid,
    input  logic [W-1:0] kvo,
    input  logic         verdict,
    output logic [W-1:0] count,
`ifdef ERR_CNT_EN
    output logic [W-1:0] err_cnt,
`endif
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [W-1:0] first_err_key
);

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   n_q, n_d;
    logic           err_q, err_d;
    logic [W-1:0]   fek_q, fek_d;
    logic           accept_start;
    logic           accept_deq;

    // start is honoured everywhere except mid-run
    assign accept_start = start && (state_q != RUN);
    assign accept_deq   = deq_valid && (state_q == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
            fek_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            n_q     <= n_d;
            err_q   <= err_d;
            fek_q   <= fek_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        n_d     = n_q;
        err_d   = err_q;
        fek_d   = fek_q;
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (accept_start) begin
                    err_d = 1'b0;
                    fek_d = '0;
                    n_d   = n_keys;
                    if (n_keys != '0) begin
                        state_d = RUN;
                        count_d = {{(W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = DONE;
                        count_d = '0;
                    end
                end
            end
            RUN: begin
                if (accept_deq) begin
                    if (verdict) begin
                        err_d = 1'b1;
                        if (!err_q) fek_d = kvo;
                    end
                    // n_q bounds count, so the increment can never wrap
                    if (count_q < n_q) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        count_d = '0;
                        state_d = (err_q || verdict) ? FAIL : DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign count         = count_q;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE) || (state_q == FAIL);
    assign pass          = (state_q == DONE);
    assign first_err_key = fek_q;

`ifdef ERR_CNT_EN
    sat_counter #(.W(W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_start),
        .inc   (accept_deq && verdict),
        .value (err_cnt)
    );
`endif

endmodule
